// File: rtl/xalu_pkg.sv
// xalu_pkg: opcode codes and FSM state type shared by the xalu_seq slice
package xalu_pkg;
  localparam logic [3:0] F_ADD = 4'd0, F_AND = 4'd1, F_OR = 4'd2, F_XOR = 4'd3;
  localparam logic [3:0] F_PASSA = 4'd4, F_PASSB = 4'd5, F_SHR1 = 4'd6, F_SHL1 = 4'd7;
  localparam logic [3:0] F_SUB = 4'd8, F_SHLN = 4'd9, F_SHRN = 4'd10, F_MUL = 4'd11;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/xalu_if.sv
// xalu_if: request operands/function (master->slave) and registered result, flags, busy/done (slave->master)
interface xalu_if #(parameter int WIDTH = 8);
  logic start;
  logic [3:0] F;
  logic COM;
  logic [WIDTH-1:0] a, b;
  logic ci_right, ci_left;
  logic [WIDTH-1:0] d;
  logic co_left, co_right, ZERO, NEG_ZERO, EQU, OVF, busy, done;
  modport master (output start, F, COM, a, b, ci_right, ci_left,
                  input d, co_left, co_right, ZERO, NEG_ZERO, EQU, OVF, busy, done);
  modport slave (input start, F, COM, a, b, ci_right, ci_left,
                 output d, co_left, co_right, ZERO, NEG_ZERO, EQU, OVF, busy, done);
endinterface

// File: rtl/xalu_comb.sv
// xalu_comb: single-cycle ALU ops (f_i, a_i, b_i, ci_right_i, ci_left_i -> d_o, co_left_o, co_right_o, ovf_o); codes 9-15 pass a
module xalu_comb import xalu_pkg::*; #(parameter int WIDTH = 8) (
  input  logic [3:0]       f_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_right_i,
  input  logic             ci_left_i,
  output logic [WIDTH-1:0] d_o,
  output logic             co_left_o,
  output logic             co_right_o,
  output logic             ovf_o
);
  localparam int M = WIDTH - 1;
  logic sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0] sum;
  assign sub = f_i == F_SUB;
  assign bx = sub ? ~b_i : b_i;
  assign sum = {1'b0, a_i} + {1'b0, bx} + {{WIDTH{1'b0}}, sub | ci_right_i};
  always_comb begin
    d_o = a_i;
    co_left_o = 1'b0;
    co_right_o = 1'b0;
    ovf_o = 1'b0;
    case (f_i)
      F_ADD, F_SUB: begin
        d_o = sum[M:0];
        co_left_o = sum[WIDTH];
        ovf_o = (a_i[M] == bx[M]) && (sum[M] != a_i[M]);
      end
      F_AND: d_o = a_i & b_i;
      F_OR: d_o = a_i | b_i;
      F_XOR: d_o = a_i ^ b_i;
      F_PASSB: d_o = b_i;
      F_SHR1: begin
        d_o = {ci_left_i, a_i[M:1]};
        co_right_o = a_i[0];
      end
      F_SHL1: begin
        d_o = {a_i[M-1:0], ci_right_i};
        co_left_o = a_i[M];
      end
      default: d_o = a_i;
    endcase
  end
endmodule

// File: rtl/xalu_seq.sv
// xalu_seq: sequential ALU (clk, rst, bus: slave side of xalu_if) with 1-bit/cycle shifts, shift-add multiply and registered result/flags
module xalu_seq import xalu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst,
  xalu_if.slave bus
);
  localparam int M = WIDTH - 1;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state_q;
  logic [WIDTH-1:0] w_q, hi_q, m_q, d_q, w_d, hi_d, c_d, r_d;
  logic [CW-1:0] cnt_q;
  logic [SHW-1:0] n;
  logic [WIDTH:0] msum;
  logic fill_q, com_q, mul_q, shl_q, pend_equ_q;
  logic co_left_q, co_right_q, zero_q, negz_q, equ_q, ovf_q, done_q;
  logic c_cl, c_cr, c_ovf, multi, run, wr, cl_d, cr_d;
  xalu_comb #(.WIDTH(WIDTH)) u_comb (
    .f_i(bus.F), .a_i(bus.a), .b_i(bus.b), .ci_right_i(bus.ci_right), .ci_left_i(bus.ci_left),
    .d_o(c_d), .co_left_o(c_cl), .co_right_o(c_cr), .ovf_o(c_ovf)
  );
  assign n = bus.b[SHW-1:0];
  assign multi = bus.F == F_MUL || ((bus.F == F_SHLN || bus.F == F_SHRN) && n != '0);
  assign run = state_q == RUN;
  // multiply: w_q holds the multiplier, consumed LSB-first while product bits shift in from hi_q
  assign msum = {1'b0, hi_q} + (w_q[0] ? {1'b0, m_q} : '0);
  assign hi_d = msum[WIDTH:1];
  assign w_d = mul_q ? {msum[0], w_q[M:1]} : shl_q ? {w_q[M-1:0], fill_q} : {fill_q, w_q[M:1]};
  assign wr = run ? cnt_q == CW'(1) : bus.start && !multi;
  assign r_d = run ? w_d ^ {WIDTH{com_q}} : c_d ^ {WIDTH{bus.COM}};
  assign cl_d = run ? (mul_q ? |hi_d : shl_q & w_q[M]) : c_cl;
  assign cr_d = run ? (!mul_q && !shl_q && w_q[0]) : c_cr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      {w_q, hi_q, m_q, d_q, cnt_q} <= '0;
      {fill_q, com_q, mul_q, shl_q, pend_equ_q} <= '0;
      {co_left_q, co_right_q, zero_q, negz_q, equ_q, ovf_q, done_q} <= '0;
    end else begin
      done_q <= wr;
      if (wr) begin
        d_q <= r_d;
        co_left_q <= cl_d;
        co_right_q <= cr_d;
        ovf_q <= run ? 1'b0 : c_ovf;
        equ_q <= run ? pend_equ_q : bus.a == bus.b;
        zero_q <= r_d == '0;
        negz_q <= &r_d;
      end
      if (run) begin
        w_q <= w_d;
        hi_q <= hi_d;
        cnt_q <= cnt_q - CW'(1);
        state_q <= cnt_q == CW'(1) ? IDLE : RUN;
      end else if (bus.start && multi) begin
        state_q <= RUN;
        w_q <= bus.F == F_MUL ? bus.b : bus.a;
        m_q <= bus.a;
        hi_q <= '0;
        mul_q <= bus.F == F_MUL;
        shl_q <= bus.F == F_SHLN;
        fill_q <= bus.F == F_SHLN ? bus.ci_right : bus.ci_left;
        com_q <= bus.COM;
        pend_equ_q <= bus.a == bus.b;
        cnt_q <= bus.F == F_MUL ? CW'(WIDTH) : CW'(n);
      end
    end
  end
  assign bus.d = d_q;
  assign bus.co_left = co_left_q;
  assign bus.co_right = co_right_q;
  assign bus.ZERO = zero_q;
  assign bus.NEG_ZERO = negz_q;
  assign bus.EQU = equ_q;
  assign bus.OVF = ovf_q;
  assign bus.busy = run;
  assign bus.done = done_q;
endmodule

// File: tb/tb_xalu_seq.sv
// tb_xalu_seq: randomized scoreboard bench for xalu_seq against an arithmetic reference model
module tb_xalu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  xalu_if #(.WIDTH(8)) bus ();
  xalu_seq #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [7:0] d;
    logic cl, cr, z, nz, eq, ov;
    int cyc;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int asserts = 0;
  int fails = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(logic [3:0] f, logic com, logic [7:0] a, logic [7:0] b, logic cir, logic cil);
    exp_t e;
    int unsigned s;
    int sv;
    int n;
    logic [15:0] t;
    logic [15:0] p;
    logic [7:0] r;
    logic [7:0] ff;
    ff = 8'hFF;
    n = int'(b[2:0]);
    e.cl = 1'b0;
    e.cr = 1'b0;
    e.ov = 1'b0;
    e.cyc = 1;
    r = a;
    case (f)
      4'd0: begin
        s = a + b + cir;
        r = s[7:0];
        e.cl = s[8];
        sv = int'($signed(a)) + int'($signed(b)) + int'(cir);
        e.ov = sv > 127 || sv < -128;
      end
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: r = a ^ b;
      4'd5: r = b;
      4'd6: begin
        r = (a >> 1) | (cil ? 8'h80 : 8'h00);
        e.cr = a[0];
      end
      4'd7: begin
        t = ({8'h00, a} << 1) | {15'd0, cir};
        r = t[7:0];
        e.cl = t[8];
      end
      4'd8: begin
        r = a - b;
        e.cl = a >= b;
        sv = int'($signed(a)) - int'($signed(b));
        e.ov = sv > 127 || sv < -128;
      end
      4'd9: begin
        t = ({8'h00, a} << n) | (cir ? (16'd1 << n) - 16'd1 : 16'd0);
        r = t[7:0];
        e.cl = n > 0 ? t[8] : 1'b0;
        e.cyc = n + 1;
      end
      4'd10: begin
        t = {a, 8'h00} >> n;
        r = t[15:8] | (cil ? ~(ff >> n) : 8'h00);
        e.cr = n > 0 ? t[7] : 1'b0;
        e.cyc = n + 1;
      end
      4'd11: begin
        p = 16'(a) * 16'(b);
        r = p[7:0];
        e.cl = p[15:8] != 8'h00;
        e.cyc = 9;
      end
      default: r = a;
    endcase
    if (com) r = ~r;
    e.d = r;
    e.z = r == 8'h00;
    e.nz = r == 8'hFF;
    e.eq = a == b;
    return e;
  endfunction
  always @(negedge clk) begin
    if (bus.done) begin
      if (q.size() == 0) begin
        asserts++;
        fails++;
        $display("FAIL spurious_done: done=1 expected no done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("d", bus.d, e.d);
        chk("co_left", bus.co_left, e.cl);
        chk("co_right", bus.co_right, e.cr);
        chk("ZERO", bus.ZERO, e.z);
        chk("NEG_ZERO", bus.NEG_ZERO, e.nz);
        chk("EQU", bus.EQU, e.eq);
        chk("OVF", bus.OVF, e.ov);
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", bus.busy, 1'b0);
      end
    end
  end
  task automatic issue(logic [3:0] f, logic com, logic [7:0] a, logic [7:0] b, logic cir, logic cil);
    exp_t e;
    int t;
    t = 0;
    @(negedge clk);
    while (bus.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy) begin
      chk("busy_timeout", bus.busy, 1'b0);
      return;
    end
    bus.start = 1'b1;
    bus.F = f;
    bus.COM = com;
    bus.a = a;
    bus.b = b;
    bus.ci_right = cir;
    bus.ci_left = cil;
    e = model(f, com, a, b, cir, cil);
    e.cyc += cyc;
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    bus.F = 4'($urandom);
    bus.COM = 1'($urandom);
    bus.ci_right = 1'($urandom);
    bus.ci_left = 1'($urandom);
    if (bus.busy && $urandom_range(0, 1) == 1) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask
  task automatic chk_zero(string nm);
    chk({nm, "_d"}, bus.d, 8'h00);
    chk({nm, "_flags"}, {bus.co_left, bus.co_right, bus.ZERO, bus.NEG_ZERO, bus.EQU, bus.OVF}, 6'b0);
    chk({nm, "_busy"}, bus.busy, 1'b0);
    chk({nm, "_done"}, bus.done, 1'b0);
  endtask
  initial begin
    int t;
    bus.start = 1'b0;
    bus.F = 4'd0;
    bus.COM = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    bus.ci_right = 1'b0;
    bus.ci_left = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    issue(4'd0, 1'b0, 8'hF0, 8'h20, 1'b1, 1'b0);
    issue(4'd8, 1'b0, 8'h80, 8'h01, 1'b0, 1'b0);
    issue(4'd8, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0);
    issue(4'd9, 1'b0, 8'h81, 8'h03, 1'b1, 1'b0);
    issue(4'd9, 1'b0, 8'h81, 8'h00, 1'b1, 1'b0);
    issue(4'd11, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
    issue(4'd11, 1'b0, 8'h0F, 8'h11, 1'b0, 1'b0);
    issue(4'd10, 1'b0, 8'h96, 8'h05, 1'b0, 1'b1);
    issue(4'd11, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("midrun_reset");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(4'd0, 1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
    repeat (250) issue(4'($urandom_range(0, 15)), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/xalu_seq.md
# xalu_seq

Parametrised sequential successor to the 4-bit ALU slice. It provides a WIDTH-bit ALU with registered result and status flags and a start/busy/done handshake. It adds subtraction with signed overflow, multi-bit barrel-free shifts (1 bit/cycle) and an iterative unsigned shift-add multiplier. It sits between the register file and the result bus of the processor datapath and replaces cascaded 4-bit slices.

## Interface
- WIDTH, 8, operand/result width; legal 4..32
- SHW, $clog2(WIDTH), width of shift count taken from b
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- F  input  4  function code, sampled with start
- COM  input  1  1's-complement final result, sampled with start
- a, b  input  WIDTH  operands, sampled with start
- ci_right, ci_left  input  1  carry-in / shift fill bits, sampled with start
- d  output  WIDTH  registered result
- co_left, co_right  output  1  registered carry/shift-out bits
- ZERO, NEG_ZERO, EQU, OVF  output  1  registered status
- busy  output  1  multi-cycle operation in progress
- done  output  1  one-cycle pulse: d and flags updated this cycle

## Operation
- F codes: 0 ADD (a+b+ci_right), 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR1 (fill ci_left), 7 SHL1 (fill ci_right), 8 SUB (a+~b+1, ci_right ignored), 9 SHLN, 10 SHRN, 11 MUL; 12-15 reserved, execute as PASSA.
- SHLN/SHRN count n = b[SHW-1:0]; each step shifts one bit, SHLN fills ci_right, SHRN fills ci_left.
- MUL: unsigned a*b, WIDTH shift-add steps; d = low WIDTH bits.
- Carries: ADD co_left = carry out; SUB co_left = 1 when a >= b unsigned (no borrow); SHL1/SHLN co_left = last bit shifted out of MSB; SHR1/SHRN co_right = last bit shifted out of LSB; MUL co_left = OR of high WIDTH product bits. A carry output not defined for the op is written 0. Shift count 0 writes both carries 0.
- OVF: signed overflow for ADD/SUB only, else 0.
- COM inverts d after the operation. Flags use the inverted value: ZERO = (d == 0) and NEG_ZERO = (d == all ones).
- EQU = (a == b) on the sampled operands, independent of F and COM.
- State machine IDLE/RUN:
  - IDLE, start, single-cycle op (0-8, 12-15, or shift with n=0) -> stay IDLE, write result, pulse done.
  - IDLE, start, SHLN/SHRN with n>0 or MUL -> RUN with step counter loaded with n or WIDTH.
  - RUN decrements each cycle. At counter 1 -> IDLE, write result, pulse done.
- start while busy=1 is ignored, with no queueing. Operand inputs may change freely while busy because copies are held internally.
- d and all flags hold their values between done pulses.
- Reset, including mid-RUN: state IDLE, d=0, co_left=co_right=0, ZERO=0, NEG_ZERO=0, EQU=0, OVF=0, busy=0, done=0. The aborted operation produces no done.

## Timing
- Single-cycle op: start sampled at edge k; d, flags and done are valid after edge k (latency 1).
- SHLN/SHRN: busy=1 from edge k through the edge before done. done arrives after edge k+n (latency n).
- MUL: done arrives after edge k+WIDTH.
- busy falls on the same edge that raises done. start in the done cycle is accepted, giving back-to-back operation with no idle gap.

## Structure
- Package xalu_pkg holds the F opcode localparams and the IDLE/RUN state typedef.
- Sub-module xalu_comb: purely combinational WIDTH-bit unit for ops 0-8 and reserved codes. It produces result, co_left, co_right and OVF.
- The xalu_seq top holds the operand/working registers, step counter, multiply accumulator, FSM and COM/flag output registers.

## Test plan
- WIDTH=8, ADD a=0xF0 b=0x20 ci_right=1 -> after 1 cycle d=0x11, co_left=1, OVF=0, done pulse, busy never high.
- SUB a=0x80 b=0x01 -> d=0x7F, co_left=1, OVF=1. SUB a=0x05 b=0x05 COM=1 -> d=0xFF, NEG_ZERO=1, EQU=1.
- SHLN a=0x81 b=3 ci_right=1 -> busy 3 cycles, done after edge k+3, d=0x0F, co_left=0. Same with b=0 -> latency 1, d=0x81.
- MUL a=0x12 b=0x34 -> done after 8 cycles, d=0xA8, co_left=1. MUL a=0x0F b=0x11 -> d=0xFF, co_left=0.
- start pulses during RUN are ignored (no extra done). A start in the done cycle runs back-to-back.
- rst asserted mid-MUL -> all outputs 0 immediately, no done pulse. A new start after reset release behaves normally.
